mem_dump_sequencer: RTL and testbench
=====================================

# mem_dump_sequencer

Post-run data-memory readout stage, directly downstream of `microprocessor`. When the processor raises `finish`, the block takes over the data-memory read port and sweeps addresses 0 to DUMP_LEN-1. It then presents each word on a valid/ready stream for the result logger or UART. After the sweep it returns the port and reports done.

## Interface
- `ADDR_W`, default 6: data-memory address width.
- `DATA_W`, default 8: data-memory word width.
- `DUMP_LEN`, default 50: number of words dumped; legal range 1 to 2^ADDR_W.
- `RD_LAT`, default 1: memory read latency in cycles; legal values 1 or 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `finish` in 1: processor run complete (level or pulse).
- `mem_own` out 1: 1 means the sequencer drives the read port; 0 means the processor owns it.
- `mem_rd` out 1: read strobe, one cycle per word.
- `mem_addr` out ADDR_W: read address.
- `mem_q` in DATA_W: read data, valid RD_LAT cycles after the `mem_rd` cycle.
- `dump_valid` out 1: stream word valid.
- `dump_ready` in 1: consumer accepts.
- `dump_data` out DATA_W: word.
- `dump_addr` out ADDR_W: address of the word.
- `dump_last` out 1: marks the final word.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: sweep complete.

## Operation
- FSM states: IDLE, GRANT, ISSUE, WAIT, PRESENT, DONE.
- **IDLE**
  - `finish`=1 sampled: go to GRANT; clear index to 0.
- **GRANT**
  - Exactly one cycle.
  - `mem_own`=1; lets the external port mux settle before the first read.
  - Goes to ISSUE.
- **ISSUE**
  - One cycle.
  - `mem_rd`=1, `mem_addr`=index.
  - Goes to WAIT with latency counter = RD_LAT.
- **WAIT**
  - Lasts RD_LAT cycles.
  - On the last WAIT cycle, `mem_q` is captured into the `dump_data` register and `dump_addr` is set to index.
  - Then goes to PRESENT.
- **PRESENT**
  - `dump_valid`=1.
  - `dump_data`, `dump_addr` and `dump_last` are held stable until the handshake `dump_valid && dump_ready`.
  - On handshake:
    - index = DUMP_LEN-1: go to DONE.
    - Otherwise: index+1, go to ISSUE.
- **DONE**
  - `done`=1, `mem_own`=0, `busy`=0.
  - Stays in DONE while `finish`=1.
  - `finish`=0: go to IDLE. No re-dump from a held `finish`.
- `dump_last` = (index == DUMP_LEN-1) while in PRESENT; 0 otherwise.
- `mem_own` is 1 in GRANT, ISSUE, WAIT and PRESENT; 0 otherwise. `mem_addr` is 0 whenever `mem_own`=0.
- Index register is ADDR_W bits wide.
  - The increment happens only when index < DUMP_LEN-1, so no wrap, including when DUMP_LEN = 2^ADDR_W.
- `finish` is ignored outside IDLE and DONE.
  - A one-cycle `finish` pulse in IDLE is sufficient to start a sweep.

## Timing
- Reset values: state IDLE; index 0; all outputs 0 (`mem_own`, `mem_rd`, `mem_addr`, `dump_valid`, `dump_data`, `dump_addr`, `dump_last`, `busy`, `done`).
- `rst` mid-sweep forces IDLE on the next edge.
  - A partially transferred word is dropped and `mem_own` falls immediately.
  - If `finish` is still 1 after reset, a fresh sweep from address 0 starts.
- Cycle numbering: `finish` sampled in cycle 0.
  - Cycle 1: GRANT.
  - Cycle 2: ISSUE with address 0.
  - Cycles 3 to 2+RD_LAT: WAIT.
  - Cycle 3+RD_LAT: `dump_valid` rises.
- Per word with `dump_ready` held at 1: RD_LAT+2 cycles.
- Full sweep: 1 + DUMP_LEN·(RD_LAT+2) cycles from GRANT to DONE.
  - Defaults (DUMP_LEN=50, RD_LAT=1): 151 cycles.
- `done` asserts the cycle after the last handshake.
- Backpressure: any number of stall cycles in PRESENT is allowed.
  - No further `mem_rd` is issued while stalled.
  - `dump_*` outputs must not change.

## Test plan
- Reset: hold `rst` for 2 cycles with `finish`=1 → all outputs 0 during reset. After release, GRANT follows on the next edge.
- Basic sweep, DUMP_LEN=4, RD_LAT=1, memory model mem[a]=a+8'h10, `dump_ready`=1:
  - Stream is (0,10),(1,11),(2,12),(3,13).
  - `dump_last` is set only on address 3.
  - `done` rises 13 cycles after GRANT.
- Backpressure, RD_LAT=2: `dump_ready` low for 5 cycles on word 1 → word 1 is held stable and `mem_rd` stays at 0 throughout. Data order and values are unchanged.
- Held `finish`: keep `finish`=1 after DONE for 20 cycles → no second `mem_rd`. Drop and re-raise `finish` → a new sweep starts from address 0.
- Reset mid-sweep: assert `rst` in PRESENT on word 2 → on the next edge `mem_own`=0 and `dump_valid`=0. A restarted sweep begins at address 0.
- Boundary, ADDR_W=2, DUMP_LEN=4: last word is address 3. The index must not wrap and produce a fifth transfer at address 0.

Source files
------------

// File: rtl/mem_dump_sequencer.sv
// mem_dump_sequencer: after the processor signals finish, takes over the
// data-memory read port and streams words 0..DUMP_LEN-1 out on a
// valid/ready interface. When the sweep is complete it hands the port back
// and reports done.
module mem_dump_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int DUMP_LEN = 50,
  parameter int RD_LAT   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              finish_i,
  output logic              mem_own_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Index of the final word. DUMP_LEN may equal 2^ADDR_W, so compare against
  // the last index rather than the length to avoid overflow.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_LEN - 1);
  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;

  // State, index, latency counter and stream word registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= 2'd0;
      data_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
    end
  end

  // Next-state logic: sweep sequencing, read-latency count, word capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    case (state_q)
      S_IDLE: begin
        if (finish_i) begin
          state_d = S_GRANT;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_q <= 2'd1) begin
          data_d  = mem_q_i;
          daddr_d = idx_q;
          state_d = S_PRESENT;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_PRESENT: begin
        if (dump_ready_i) begin
          // Increment only below the last index so the counter never wraps.
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_DONE: begin
        // A held finish must not retrigger; wait for it to drop first.
        if (!finish_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so outputs are glitch-free.
  always_comb begin
    mem_own_o    = 1'b0;
    mem_rd_o     = 1'b0;
    dump_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      S_GRANT:   mem_own_o = 1'b1;
      S_ISSUE: begin
        mem_own_o = 1'b1;
        mem_rd_o  = 1'b1;
      end
      S_WAIT:    mem_own_o = 1'b1;
      S_PRESENT: begin
        mem_own_o    = 1'b1;
        dump_valid_o = 1'b1;
      end
      S_DONE:    done_o = 1'b1;
      default:   mem_own_o = 1'b0;
    endcase
    busy_o      = mem_own_o;
    mem_addr_o  = mem_own_o ? idx_q : '0;
    dump_last_o = dump_valid_o && (idx_q == LAST_IDX);
    dump_data_o = data_q;
    dump_addr_o = daddr_q;
  end

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed bench for mem_dump_sequencer: three instances cover the basic
// sweep/held finish/mid-sweep reset (RD_LAT=1), backpressure (RD_LAT=2)
// and the 2-bit address boundary case.
module tb_mem_dump_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n, rdcnt, stall, donecnt;
  logic got_done;

  // Instance A: ADDR_W=6, DUMP_LEN=4, RD_LAT=1
  logic       a_fin, a_rdy, a_own, a_rd, a_valid, a_last, a_busy, a_done;
  logic [5:0] a_addr, a_daddr;
  logic [7:0] a_q, a_data;
  // Instance B: ADDR_W=6, DUMP_LEN=4, RD_LAT=2
  logic       b_fin, b_rdy, b_own, b_rd, b_valid, b_last, b_busy, b_done;
  logic [5:0] b_addr, b_daddr;
  logic [7:0] b_q, b_p1, b_data;
  // Instance C: ADDR_W=2, DUMP_LEN=4, RD_LAT=1
  logic       c_fin, c_rdy, c_own, c_rd, c_valid, c_last, c_busy, c_done;
  logic [1:0] c_addr, c_daddr;
  logic [7:0] c_q, c_data;

  mem_dump_sequencer #(.ADDR_W(6), .DATA_W(8), .DUMP_LEN(4), .RD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .finish_i(a_fin), .mem_own_o(a_own), .mem_rd_o(a_rd),
    .mem_addr_o(a_addr), .mem_q_i(a_q), .dump_valid_o(a_valid), .dump_ready_i(a_rdy),
    .dump_data_o(a_data), .dump_addr_o(a_daddr), .dump_last_o(a_last),
    .busy_o(a_busy), .done_o(a_done));

  mem_dump_sequencer #(.ADDR_W(6), .DATA_W(8), .DUMP_LEN(4), .RD_LAT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .finish_i(b_fin), .mem_own_o(b_own), .mem_rd_o(b_rd),
    .mem_addr_o(b_addr), .mem_q_i(b_q), .dump_valid_o(b_valid), .dump_ready_i(b_rdy),
    .dump_data_o(b_data), .dump_addr_o(b_daddr), .dump_last_o(b_last),
    .busy_o(b_busy), .done_o(b_done));

  mem_dump_sequencer #(.ADDR_W(2), .DATA_W(8), .DUMP_LEN(4), .RD_LAT(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .finish_i(c_fin), .mem_own_o(c_own), .mem_rd_o(c_rd),
    .mem_addr_o(c_addr), .mem_q_i(c_q), .dump_valid_o(c_valid), .dump_ready_i(c_rdy),
    .dump_data_o(c_data), .dump_addr_o(c_daddr), .dump_last_o(c_last),
    .busy_o(c_busy), .done_o(c_done));

  // Memory models mem[a] = a + 8'h10; data is only meaningful RD_LAT cycles
  // after a read strobe, otherwise a marker value 8'hEE is returned.
  always @(posedge clk) begin
    a_q  <= a_rd ? ({2'b00, a_addr} + 8'h10) : 8'hEE;
    b_p1 <= b_rd ? ({2'b00, b_addr} + 8'h10) : 8'hEE;
    b_q  <= b_p1;
    c_q  <= c_rd ? ({6'b000000, c_addr} + 8'h10) : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_fin = 1'b1; a_rdy = 1'b1;
    b_fin = 1'b0; b_rdy = 1'b1;
    c_fin = 1'b0; c_rdy = 1'b1;

    // Reset held two cycles with finish high: everything must read 0.
    repeat (2) begin
      @(negedge clk);
      chk("rst_own",   32'(a_own),   32'd0);
      chk("rst_rd",    32'(a_rd),    32'd0);
      chk("rst_addr",  32'(a_addr),  32'd0);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_data",  32'(a_data),  32'd0);
      chk("rst_daddr", 32'(a_daddr), 32'd0);
      chk("rst_last",  32'(a_last),  32'd0);
      chk("rst_busy",  32'(a_busy),  32'd0);
      chk("rst_done",  32'(a_done),  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("grant_own",  32'(a_own),  32'd1);
    chk("grant_busy", 32'(a_busy), 32'd1);
    chk("grant_rd",   32'(a_rd),   32'd0);

    // Basic sweep; finish stays high throughout.
    n = 0; rdcnt = 0; got_done = 1'b0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clk);
      if (a_rd) rdcnt++;
      if (a_valid && a_rdy) begin
        chk("sw_addr", 32'(a_daddr), 32'(n));
        chk("sw_data", 32'(a_data),  32'(n + 16));
        chk("sw_last", 32'(a_last),  32'(n == 3));
        n++;
      end else begin
        chk("sw_last0", 32'(a_last), 32'd0);
        if (a_done) begin
          chk("sw_done_cyc", 32'(k), 32'd13);
          got_done = 1'b1;
        end
      end
    end
    chk("sw_done",  32'(got_done), 32'd1);
    chk("sw_words", 32'(n),        32'd4);
    chk("sw_rds",   32'(rdcnt),    32'd4);

    // Held finish after DONE: no re-dump.
    rdcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_rd) rdcnt++;
    end
    chk("held_rd",   32'(rdcnt),  32'd0);
    chk("held_done", 32'(a_done), 32'd1);
    chk("held_own",  32'(a_own),  32'd0);
    chk("held_busy", 32'(a_busy), 32'd0);

    // Drop and re-raise finish (one-cycle pulse) to start a new sweep.
    a_fin = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(a_done), 32'd0);
    chk("idle_own",  32'(a_own),  32'd0);
    a_fin = 1'b1;
    @(negedge clk);
    chk("re_grant", 32'(a_own), 32'd1);
    a_fin = 1'b0;
    @(negedge clk);
    chk("re_rd",   32'(a_rd),   32'd1);
    chk("re_addr", 32'(a_addr), 32'd0);

    // Advance to PRESENT of word 2 (WAIT,P0,I1,W1,P1,I2,W2,P2).
    repeat (8) @(negedge clk);
    chk("mid_valid", 32'(a_valid), 32'd1);
    chk("mid_addr",  32'(a_daddr), 32'd2);
    chk("mid_data",  32'(a_data),  32'h12);
    rst = 1'b1; a_fin = 1'b1;
    @(negedge clk);
    chk("mr_own",   32'(a_own),   32'd0);
    chk("mr_valid", 32'(a_valid), 32'd0);
    chk("mr_busy",  32'(a_busy),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_grant", 32'(a_own), 32'd1);
    a_fin = 1'b0;
    @(negedge clk);
    chk("mr_rd",   32'(a_rd),   32'd1);
    chk("mr_addr", 32'(a_addr), 32'd0);
    got_done = 1'b0;
    for (int k = 1; k <= 30 && !got_done; k++) begin
      @(negedge clk);
      if (a_done) got_done = 1'b1;
    end
    chk("mr_done", 32'(got_done), 32'd1);

    // Backpressure on instance B: word 1 stalled for 5 cycles.
    b_fin = 1'b1;
    @(negedge clk);
    chk("bp_grant", 32'(b_own), 32'd1);
    b_fin = 1'b0;
    n = 0; rdcnt = 0; stall = 0; got_done = 1'b0;
    for (int k = 1; k <= 60 && !got_done; k++) begin
      @(negedge clk);
      if (b_rd) rdcnt++;
      if (b_done) begin
        chk("bp_done_cyc", 32'(k), 32'd22);
        got_done = 1'b1;
      end else if (b_valid) begin
        if (n == 1 && stall < 5) begin
          b_rdy = 1'b0;
          stall++;
          chk("bp_hold_addr", 32'(b_daddr), 32'd1);
          chk("bp_hold_data", 32'(b_data),  32'h11);
          chk("bp_hold_last", 32'(b_last),  32'd0);
          chk("bp_hold_rd",   32'(b_rd),    32'd0);
        end else begin
          b_rdy = 1'b1;
          chk("bp_addr", 32'(b_daddr), 32'(n));
          chk("bp_data", 32'(b_data),  32'(n + 16));
          chk("bp_last", 32'(b_last),  32'(n == 3));
          n++;
        end
      end else begin
        b_rdy = 1'b1;
      end
    end
    chk("bp_done",  32'(got_done), 32'd1);
    chk("bp_words", 32'(n),        32'd4);
    chk("bp_rds",   32'(rdcnt),    32'd4);
    chk("bp_stall", 32'(stall),    32'd5);

    // Boundary on instance C: 2-bit index, last word is address 3, no wrap.
    c_fin = 1'b1;
    @(negedge clk);
    chk("bd_grant", 32'(c_own), 32'd1);
    c_fin = 1'b0;
    n = 0; rdcnt = 0; donecnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (c_rd) rdcnt++;
      if (c_valid && c_rdy) begin
        chk("bd_addr", 32'(c_daddr), 32'(n));
        chk("bd_data", 32'(c_data),  32'(n + 16));
        chk("bd_last", 32'(c_last),  32'(n == 3));
        n++;
      end
      if (c_done) begin
        donecnt++;
        if (donecnt == 1) chk("bd_done_cyc", 32'(k), 32'd13);
      end
    end
    chk("bd_words", 32'(n),       32'd4);
    chk("bd_rds",   32'(rdcnt),   32'd4);
    chk("bd_done",  32'(donecnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
